// File: rtl/fu_issue_ctrl.sv
// Issue controller: hazard checks for the ID instruction plus a latency-indexed
// write-back reservation table and per-FU / per-register busy tracking.
module fu_issue_ctrl #(
  parameter int unsigned FU_NUM         = 6,
  parameter int unsigned MAX_FU_LATENCY = 31,
  parameter int unsigned FU_ID_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [FU_ID_W-1:0]   issue_fu,
  input  logic [4:0]           issue_latency,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  input  logic                 issue_use_rs1,
  input  logic                 issue_use_rs2,
  output logic                 issue_ready,
  output logic                 stall_struct,
  output logic                 stall_data,
  output logic [FU_NUM-1:0]    fu_status,
  output logic [FU_NUM*5-1:0]  fu_write_to,
  output logic [FU_NUM-1:0]    fu_writeback_en,
  output logic [31:0]          reg_pending
);

  localparam int unsigned Slots = MAX_FU_LATENCY + 1;

  logic [FU_ID_W-1:0] slot_q [Slots];
  logic [FU_NUM-1:0]  fu_status_q;
  logic [4:0]         fu_rd_q [FU_NUM];
  logic [31:0]        pending_q;

  logic               fu_ok, lat_ok, req_ok;
  logic               fu_busy, slot_hit, struct_bad;
  logic               raw1, raw2, waw, data_bad;
  logic               accept;
  logic [FU_ID_W-1:0] wb_fu;

  assign wb_fu       = slot_q[0];
  assign fu_status   = fu_status_q;
  assign reg_pending = pending_q;

  always_comb begin
    fu_ok  = (issue_fu != '0) && ({1'b0, issue_fu} < (FU_ID_W + 1)'(FU_NUM));
    lat_ok = (issue_latency != 5'd0) && (6'(issue_latency) <= 6'(MAX_FU_LATENCY));
    fu_busy = fu_ok && fu_status_q[issue_fu];
    // Collision is checked against the pre-shift table at index issue_latency.
    slot_hit = 1'b0;
    for (int unsigned k = 0; k < Slots; k++) begin
      if ((6'(k) == 6'(issue_latency)) && (slot_q[k] != '0)) slot_hit = 1'b1;
    end
    struct_bad = fu_busy || slot_hit;

    raw1     = issue_use_rs1 && (issue_rs1 != 5'd0) && pending_q[issue_rs1];
    raw2     = issue_use_rs2 && (issue_rs2 != 5'd0) && pending_q[issue_rs2];
    waw      = (issue_rd != 5'd0) && pending_q[issue_rd];
    data_bad = raw1 || raw2 || waw;

    req_ok       = !rst && fu_ok && lat_ok;
    issue_ready  = req_ok && !struct_bad && !data_bad;
    stall_struct = req_ok && issue_valid && struct_bad;
    stall_data   = req_ok && issue_valid && data_bad;
    accept       = issue_valid && issue_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      fu_writeback_en[i] = (i != 0) && (wb_fu == FU_ID_W'(i));
      fu_write_to[5*i +: 5] = fu_rd_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < Slots; k++) slot_q[k] <= '0;
      for (int unsigned i = 0; i < FU_NUM; i++) fu_rd_q[i] <= '0;
      fu_status_q <= '0;
      pending_q   <= '0;
    end else begin
      for (int unsigned k = 0; k + 1 < Slots; k++) slot_q[k] <= slot_q[k+1];
      slot_q[Slots-1] <= '0;
      if (accept) slot_q[issue_latency - 5'd1] <= issue_fu;

      // Completion first; an accept to a different FU/rd in the same cycle still lands.
      if (wb_fu != '0) begin
        fu_status_q[wb_fu]         <= 1'b0;
        pending_q[fu_rd_q[wb_fu]]  <= 1'b0;
      end
      if (accept) begin
        fu_status_q[issue_fu] <= 1'b1;
        fu_rd_q[issue_fu]     <= issue_rd;
        if (issue_rd != 5'd0) pending_q[issue_rd] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl: directed vector table, hand sequences and random
// stimulus checked against an in-flight-list model.
module tb_fu_issue_ctrl;
  localparam int FuNum  = 6;
  localparam int MaxLat = 31;
  localparam int FuIdW  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             issue_valid = 1'b0;
  logic [FuIdW-1:0] issue_fu = '0;
  logic [4:0]       issue_latency = '0, issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic             issue_use_rs1 = 1'b0, issue_use_rs2 = 1'b0;
  logic             issue_ready, stall_struct, stall_data;
  logic [FuNum-1:0] fu_status, fu_writeback_en;
  logic [FuNum*5-1:0] fu_write_to;
  logic [31:0]      reg_pending;

  fu_issue_ctrl #(.FU_NUM(FuNum), .MAX_FU_LATENCY(MaxLat), .FU_ID_W(FuIdW)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_latency(issue_latency), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_ready(issue_ready), .stall_struct(stall_struct), .stall_data(stall_data),
    .fu_status(fu_status), .fu_write_to(fu_write_to), .fu_writeback_en(fu_writeback_en),
    .reg_pending(reg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fu;
    int rd;
    int wb;
  } flight_t;

  typedef struct {
    bit v; int fu; int lat; int rd; int rs1; int rs2; bit u1; bit u2;
    bit er; bit ess; bit esd; logic [5:0] ewb;
  } vec_t;

  flight_t q[$];
  int      cyc;
  int      last_rd[FuNum];
  int      checks = 0;
  int      errors = 0;
  vec_t    tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, int fu, int lat, int rd, int rs1, int rs2, bit u1, bit u2,
                              bit er, bit ess, bit esd, logic [5:0] ewb);
    vec_t t;
    t.v = v; t.fu = fu; t.lat = lat; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = u1; t.u2 = u2; t.er = er; t.ess = ess; t.esd = esd; t.ewb = ewb;
    return t;
  endfunction

  function automatic vec_t idle(logic [5:0] ewb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ewb);
  endfunction

  // One cycle: drive, compare every output with the model at negedge, advance the model.
  task automatic step(input bit v, input int fu, input int lat, input int rd, input int rs1,
                      input int rs2, input bit u1, input bit u2,
                      output logic r, output logic ss, output logic sd, output logic [5:0] wb);
    logic [5:0]  busy, wbm;
    logic [31:0] pend;
    logic [29:0] wt;
    bit          coll, vreq, sb, db, er;
    flight_t     nq[$];
    flight_t     e;
    issue_valid = v; issue_fu = FuIdW'(fu); issue_latency = 5'(lat); issue_rd = 5'(rd);
    issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_use_rs1 = u1; issue_use_rs2 = u2;
    busy = '0; wbm = '0; pend = '0; coll = 0;
    foreach (q[j]) begin
      busy[q[j].fu] = 1'b1;
      if (q[j].rd != 0) pend[q[j].rd] = 1'b1;
      if (q[j].wb == cyc) wbm[q[j].fu] = 1'b1;
      if (q[j].wb == cyc + lat) coll = 1;
    end
    for (int i = 0; i < FuNum; i++) wt[5*i +: 5] = 5'(last_rd[i]);
    vreq = (fu >= 1) && (fu < FuNum) && (lat >= 1) && (lat <= MaxLat);
    sb = 0;
    if (vreq) sb = busy[fu] || coll;
    db = (u1 && rs1 != 0 && pend[rs1]) || (u2 && rs2 != 0 && pend[rs2]) ||
         (rd != 0 && pend[rd]);
    er = vreq && !sb && !db;
    @(negedge clk);
    chk("issue_ready", 32'(issue_ready), 32'(er));
    chk("stall_struct", 32'(stall_struct), 32'(v && vreq && sb));
    chk("stall_data", 32'(stall_data), 32'(v && vreq && db));
    chk("fu_status", 32'(fu_status), 32'(busy));
    chk("fu_writeback_en", 32'(fu_writeback_en), 32'(wbm));
    chk("fu_write_to", 32'(fu_write_to), 32'(wt));
    chk("reg_pending", reg_pending, pend);
    r = issue_ready; ss = stall_struct; sd = stall_data; wb = fu_writeback_en;
    @(posedge clk);
    foreach (q[j]) if (q[j].wb != cyc) nq.push_back(q[j]);
    q = nq;
    if (v && er) begin
      e.fu = fu; e.rd = rd; e.wb = cyc + lat;
      q.push_back(e);
      last_rd[fu] = rd;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_step(output logic [5:0] wb);
    logic r, ss, sd;
    step(0, 0, 0, 0, 0, 0, 0, 0, r, ss, sd, wb);
  endtask

  // Reset with a request that would otherwise be accepted; outputs must clear at once.
  task automatic do_reset();
    issue_valid = 1; issue_fu = 1; issue_latency = 1; issue_rd = 1;
    issue_use_rs1 = 0; issue_use_rs2 = 0;
    rst = 1'b1;
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 0);
    chk("rst_stall_struct", 32'(stall_struct), 0);
    chk("rst_stall_data", 32'(stall_data), 0);
    chk("rst_fu_status", 32'(fu_status), 0);
    chk("rst_fu_write_to", 32'(fu_write_to), 0);
    chk("rst_fu_writeback_en", 32'(fu_writeback_en), 0);
    chk("rst_reg_pending", reg_pending, 0);
    q.delete();
    foreach (last_rd[i]) last_rd[i] = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic       r, ss, sd;
    logic [5:0] wb;
    #1;
    do_reset();

    // Cycle-indexed directed vectors starting right after reset.
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 0
    tbl.push_back(idle(6'b000010));                                // 1
    tbl.push_back(idle(6'b000000));                                // 2
    tbl.push_back(mk(1, 2, 4, 6, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 3
    tbl.push_back(mk(1, 3, 3, 8, 0, 0, 0, 0, 0, 1, 0, 6'b000000)); // 4 slot collision
    tbl.push_back(mk(1, 3, 3, 8, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 5
    tbl.push_back(idle(6'b000000));                                // 6
    tbl.push_back(idle(6'b000100));                                // 7
    tbl.push_back(idle(6'b001000));                                // 8
    tbl.push_back(mk(1, 2, 4, 9, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 9
    for (int c = 10; c <= 13; c++)                                 // FU busy incl. wb cycle
      tbl.push_back(mk(1, 2, 1, 10, 0, 0, 0, 0, 0, 1, 0, (c == 13) ? 6'b000100 : 6'b0));
    tbl.push_back(mk(1, 2, 1, 10, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 14
    tbl.push_back(idle(6'b000100));                                 // 15
    tbl.push_back(mk(1, 1, 3, 7, 0, 0, 0, 0, 1, 0, 0, 6'b000000));  // 16
    for (int c = 17; c <= 19; c++)                                  // RAW on x7
      tbl.push_back(mk(1, 3, 5, 11, 7, 0, 1, 0, 0, 0, 1, (c == 19) ? 6'b000010 : 6'b0));
    tbl.push_back(mk(1, 3, 5, 11, 7, 0, 1, 0, 1, 0, 0, 6'b000000)); // 20
    tbl.push_back(mk(1, 1, 3, 7, 0, 0, 0, 0, 1, 0, 0, 6'b000000));  // 21
    for (int c = 22; c <= 24; c++)                                  // WAW on x7
      tbl.push_back(mk(1, 4, 4, 7, 0, 0, 0, 0, 0, 0, 1, (c == 24) ? 6'b000010 : 6'b0));
    tbl.push_back(mk(1, 4, 4, 7, 0, 0, 0, 0, 1, 0, 0, 6'b001000));  // 25
    tbl.push_back(mk(1, 5, 6, 12, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 26
    tbl.push_back(mk(1, 5, 2, 13, 0, 12, 0, 1, 0, 1, 1, 6'b000000)); // 27 both stalls
    tbl.push_back(idle(6'b000000));                                 // 28
    tbl.push_back(idle(6'b010000));                                 // 29
    tbl.push_back(idle(6'b000000));                                 // 30
    tbl.push_back(idle(6'b000000));                                 // 31
    tbl.push_back(idle(6'b100000));                                 // 32
    tbl.push_back(idle(6'b000000));                                 // 33
    tbl.push_back(mk(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000));  // 34 fu 0
    tbl.push_back(mk(1, 6, 3, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000));  // 35 fu 6
    tbl.push_back(mk(1, 7, 3, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000));  // 36 fu 7
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000));  // 37 lat 0
    tbl.push_back(mk(1, 1, 31, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000)); // 38 lat 31

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].fu, tbl[i].lat, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
           tbl[i].u1, tbl[i].u2, r, ss, sd, wb);
      chk($sformatf("vec%0d_ready", i), 32'(r), 32'(tbl[i].er));
      chk($sformatf("vec%0d_stall_struct", i), 32'(ss), 32'(tbl[i].ess));
      chk($sformatf("vec%0d_stall_data", i), 32'(sd), 32'(tbl[i].esd));
      chk($sformatf("vec%0d_wb", i), 32'(wb), 32'(tbl[i].ewb));
    end

    // Latency-31 issue from cycle 38 writes back in cycle 69 and not before.
    for (int c = 39; c <= 68; c++) begin
      idle_step(wb);
      chk("lat31_early_wb", 32'(wb), 0);
    end
    idle_step(wb);
    chk("lat31_wb", 32'(wb), 32'(6'b000010));

    // Reset with three instructions in flight; nothing may write back afterwards.
    step(1, 1, 5, 1, 0, 0, 0, 0, r, ss, sd, wb);
    step(1, 2, 6, 2, 0, 0, 0, 0, r, ss, sd, wb);
    step(1, 3, 7, 3, 0, 0, 0, 0, r, ss, sd, wb);
    idle_step(wb);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_step(wb);
      chk("post_rst_wb", 32'(wb), 0);
    end

    // Random traffic with small register and latency ranges to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int lat;
      if (n % 700 == 699) do_reset();
      lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), lat, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), r, ss, sd, wb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
